// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared state encodings, register offsets and base address for int_ctrl
package int_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;
  localparam logic [2:0] REG_PEND = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd1;
  localparam logic [2:0] REG_ACK  = 3'd2;
  localparam logic [2:0] REG_CUR  = 3'd3;
  localparam logic [2:0] REG_CFG  = 3'd4;
  localparam logic [31:0] INTC_BASE = 32'h0000_7f30;
endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: bridge register bus plus CP0 request/taken/return handshake
interface int_ctrl_if #(
  parameter int ID_W = 3
);
  logic [2:0]      addr;
  logic            we;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            irq;
  logic [ID_W-1:0] cur_id;
  logic            int_taken;
  logic            eret;
  modport master (
    output addr, we, wdata, int_taken, eret,
    input  rdata, irq, cur_id
  );
  modport slave (
    input  addr, we, wdata, int_taken, eret,
    output rdata, irq, cur_id
  );
endinterface

// File: rtl/int_ctrl_prio_enc.sv
// prio_enc: lowest-index-first priority encoder with valid flag
module prio_enc #(
  parameter int NUM_SRC = 6,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               valid
);
  // scan from the top down so the lowest set index is the last one written
  always_comb begin
    id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req[i]) id = ID_W'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller with edge capture, mask, fixed priority and CP0 handshake; INTC_LEVEL_EN adds per-source level mode via CFG
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 6,
  parameter int ID_W    = 3
) (
  input logic               clk,
  input logic               reset,
  input logic [NUM_SRC-1:0] src,
  int_ctrl_if.slave         bus
);
  localparam int PAD = 32 - NUM_SRC;
  state_t             state, state_nxt;
  logic [ID_W-1:0]    cur_id, cur_id_nxt;
  logic [NUM_SRC-1:0] src_q, pend, mask, pend_nxt, ack, lvl, hit;
  logic [ID_W-1:0]    enc_id;
  logic               enc_valid;
  logic               unused_wdata;
  assign unused_wdata = ^bus.wdata[31:NUM_SRC];
  assign ack = (bus.we && bus.addr == REG_ACK) ? bus.wdata[NUM_SRC-1:0] : '0;
  assign hit = pend & mask;
`ifdef INTC_LEVEL_EN
  logic [NUM_SRC-1:0] cfg;
  // per-source level/edge selection
  always_ff @(posedge clk)
    if (reset) cfg <= '0;
    else if (bus.we && bus.addr == REG_CFG) cfg <= bus.wdata[NUM_SRC-1:0];
  assign lvl = cfg;
`else
  assign lvl = '0;
`endif
  // level sources follow the pin; edge sources set on rising edge, and a new edge beats a same-cycle ACK
  assign pend_nxt = (lvl & src) | (~lvl & ((pend & ~ack) | (src & ~src_q)));
  // source sampling, pending latch and mask register
  always_ff @(posedge clk)
    if (reset) begin
      src_q <= '0;
      pend  <= '0;
      mask  <= '0;
    end else begin
      src_q <= src;
      pend  <= pend_nxt;
      if (bus.we && bus.addr == REG_MASK) mask <= bus.wdata[NUM_SRC-1:0];
    end
  prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_enc (
    .req   (hit),
    .id    (enc_id),
    .valid (enc_valid)
  );
  // request state and the source it refers to
  always_ff @(posedge clk)
    if (reset) begin
      state  <= ST_IDLE;
      cur_id <= '0;
    end else begin
      state  <= state_nxt;
      cur_id <= cur_id_nxt;
    end
  // arbitrate only in IDLE; withdraw the request if its source is acked or masked before CP0 takes it
  always_comb begin
    state_nxt  = state;
    cur_id_nxt = cur_id;
    case (state)
      ST_IDLE: if (enc_valid) begin
        state_nxt  = ST_REQ;
        cur_id_nxt = enc_id;
      end
      ST_REQ: state_nxt = bus.int_taken ? ST_SERVICE : (hit[cur_id] ? ST_REQ : ST_IDLE);
      ST_SERVICE: state_nxt = bus.eret ? ST_IDLE : ST_SERVICE;
      default: state_nxt = ST_IDLE;
    endcase
  end
  assign bus.irq    = state == ST_REQ;
  assign bus.cur_id = cur_id;
  assign bus.rdata  = bus.addr == REG_PEND ? {{PAD{1'b0}}, pend} :
                      bus.addr == REG_MASK ? {{PAD{1'b0}}, mask} :
                      bus.addr == REG_CUR  ? {{(30-ID_W){1'b0}}, state, cur_id} :
                      bus.addr == REG_CFG  ? {{PAD{1'b0}}, lvl} : 32'd0;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed stimulus against a behavioural model of int_ctrl, plus literal spot checks
module tb_int_ctrl;
  logic       clk = 0;
  logic       reset = 1;
  logic [5:0] src = '0;
  int         npass = 0;
  int         ntotal = 0;
  bit         started = 0;
  int_ctrl_if #(.ID_W(3)) bus ();
  int_ctrl #(.NUM_SRC(6), .ID_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  // model: state 0 idle, 1 requesting, 2 in service
  int         m_state;
  int         m_id;
  logic [5:0] m_pend, m_mask, m_cfg, m_prev, m_ack;
  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction
  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {26'd0, m_pend};
      3'd1: return {26'd0, m_mask};
      3'd3: return 32'(m_state * 8 + m_id);
`ifdef INTC_LEVEL_EN
      3'd4: return {26'd0, m_cfg};
`endif
      default: return 32'd0;
    endcase
  endfunction
  always @(posedge clk) begin
    started <= 1;
    if (reset) begin
      m_state = 0; m_id = 0; m_pend = 0; m_mask = 0; m_cfg = 0; m_prev = 0;
    end else begin
      if (m_state == 0 && (m_pend & m_mask) != 0) begin
        m_id = lowest(m_pend & m_mask);
        m_state = 1;
      end else if (m_state == 1 && bus.int_taken) m_state = 2;
      else if (m_state == 1 && !(m_pend[m_id] && m_mask[m_id])) m_state = 0;
      else if (m_state == 2 && bus.eret) m_state = 0;
      m_ack = (bus.we && bus.addr == 3'd2) ? bus.wdata[5:0] : 6'd0;
      for (int i = 0; i < 6; i++)
        m_pend[i] = m_cfg[i] ? src[i] : ((m_pend[i] && !m_ack[i]) || (src[i] && !m_prev[i]));
      if (bus.we && bus.addr == 3'd1) m_mask = bus.wdata[5:0];
`ifdef INTC_LEVEL_EN
      if (bus.we && bus.addr == 3'd4) m_cfg = bus.wdata[5:0];
`endif
      m_prev = src;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) if (started) begin
    chk("model_irq", 32'(bus.irq), 32'(m_state == 1));
    chk("model_cur_id", 32'(bus.cur_id), 32'(m_id));
    chk("model_rdata", bus.rdata, m_read(bus.addr));
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #2;
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.addr = a; bus.we = 1; bus.wdata = d;
    tick();
    bus.we = 0;
  endtask
  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(name, bus.rdata, exp);
  endtask
  task automatic pulse_src(input logic [5:0] v);
    src = v; tick(); src = 0;
  endtask
  task automatic take();
    bus.int_taken = 1; tick(); bus.int_taken = 0;
  endtask
  task automatic ret();
    bus.eret = 1; tick(); bus.eret = 0;
  endtask
  initial begin
    bus.addr = 0; bus.we = 0; bus.wdata = 0; bus.int_taken = 0; bus.eret = 0;
    tick(2);
    reset = 0;
    rd("reset_pend", 3'd0, 0);
    chk("reset_irq", 32'(bus.irq), 0);
    // single edge: pend after 1 cycle, request the cycle after
    wr(3'd1, 32'h3f);
    pulse_src(6'h04);
    rd("edge_pend", 3'd0, 32'h04);
    chk("edge_irq_low", 32'(bus.irq), 0);
    tick();
    chk("req_irq", 32'(bus.irq), 1);
    rd("req_cur", 3'd3, 32'h0a);
    take();
    rd("service_cur", 3'd3, 32'h12);
    wr(3'd2, 32'h04);
    ret();
    // two sources together: lower index first, the other after eret
    pulse_src(6'h12);
    tick();
    chk("prio_id", 32'(bus.cur_id), 1);
    take();
    chk("taken_irq", 32'(bus.irq), 0);
    rd("taken_cur", 3'd3, 32'h11);
    wr(3'd2, 32'h02);
    ret();
    chk("eret_plus1_irq", 32'(bus.irq), 0);
    tick();
    chk("rereq_irq", 32'(bus.irq), 1);
    chk("rereq_id", 32'(bus.cur_id), 4);
    take(); wr(3'd2, 32'h10); ret();
    // masked source stays pending without a request until unmasked
    wr(3'd1, 32'h00);
    pulse_src(6'h01);
    tick();
    rd("masked_pend", 3'd0, 32'h01);
    chk("masked_irq", 32'(bus.irq), 0);
    wr(3'd1, 32'h01);
    tick();
    chk("unmask_irq", 32'(bus.irq), 1);
    take(); wr(3'd2, 32'h01); ret();
    // ACK of the requested source before int_taken withdraws and re-arbitrates
    wr(3'd1, 32'h3f);
    pulse_src(6'h08);
    tick();
    chk("req3_id", 32'(bus.cur_id), 3);
    pulse_src(6'h20);
    wr(3'd2, 32'h08);
    chk("ack_irq_still", 32'(bus.irq), 1);
    tick();
    chk("withdraw_irq", 32'(bus.irq), 0);
    tick();
    chk("req5_irq", 32'(bus.irq), 1);
    chk("req5_id", 32'(bus.cur_id), 5);
    take(); wr(3'd2, 32'h20); ret();
    // same-cycle edge and ACK: set wins
    wr(3'd1, 32'h00);
    src = 6'h01; bus.addr = 3'd2; bus.we = 1; bus.wdata = 32'h01;
    tick();
    bus.we = 0; src = 0;
    rd("setwins_pend", 3'd0, 32'h01);
    wr(3'd2, 32'h01);
    rd("ack_pend", 3'd0, 32'h00);
    // unused and write-only registers read zero
    wr(3'd5, 32'hffff_ffff);
    rd("ack_reads0", 3'd2, 0);
    rd("addr5_0", 3'd5, 0);
    rd("addr6_0", 3'd6, 0);
    rd("addr7_0", 3'd7, 0);
`ifndef INTC_LEVEL_EN
    wr(3'd4, 32'h3f);
    rd("cfg_absent", 3'd4, 0);
`endif
    // reset in the middle of service
    wr(3'd1, 32'h3f);
    pulse_src(6'h21);
    tick();
    take();
    rd("svc_pend", 3'd0, 32'h21);
    rd("svc_cur", 3'd3, 32'h10);
    reset = 1; tick(); reset = 0;
    rd("rst_pend", 3'd0, 0);
    rd("rst_mask", 3'd1, 0);
    rd("rst_cur", 3'd3, 0);
    chk("rst_irq", 32'(bus.irq), 0);
    ret();
    rd("stray_eret_cur", 3'd3, 0);
`ifdef INTC_LEVEL_EN
    // level source ignores ACK and follows the pin
    wr(3'd4, 32'h01);
    rd("cfg_read", 3'd4, 32'h01);
    src = 6'h01;
    tick(2);
    rd("lvl_pend", 3'd0, 32'h01);
    wr(3'd2, 32'h01);
    rd("lvl_ack_pend", 3'd0, 32'h01);
    src = 0;
    tick();
    rd("lvl_fall_pend", 3'd0, 32'h00);
`endif
    tick(2);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
